// File: rtl/sar_pkg.sv
// Shared types and constants for the successive-approximation search engine.
package sar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRIAL = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_LIN = 1'b0;
  localparam logic MODE_SQ  = 1'b1;

endpackage

// File: rtl/sar_search_engine_if.sv
// Control/result bundle between the requesting FSM and the search engine.
interface sar_search_engine_if #(
  parameter int XW = 8,
  parameter int YW = 10
);
  logic          start;
  logic          mode;
  logic [YW-1:0] target;
  logic          busy;
  logic          done;
  logic          exact;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  modport master (output start, mode, target, input busy, done, exact, x, y);
  modport slave  (input start, mode, target, output busy, done, exact, x, y);
endinterface

// File: rtl/sar_func.sv
// Transfer function f(x, mode) at full width; no saturation here.
module sar_func
  import sar_pkg::*;
#(
  parameter int XW       = 8,
  parameter int GAIN     = 3,
  parameter int SQ_SHIFT = 6,
  parameter int FW       = 16
) (
  input  logic [XW-1:0] x,
  input  logic          mode,
  output logic [FW-1:0] f
);

  logic [FW-1:0] lin;
  logic [FW-1:0] prod;
  logic [FW-1:0] sq;

  // FW is at least 2*XW, so the square never overflows before the shift
  always_comb begin
    lin  = FW'(x) * FW'(GAIN);
    prod = FW'(x) * FW'(x);
    sq   = prod >> SQ_SHIFT;
    f    = lin;
    case (mode)
      MODE_LIN: f = lin;
      MODE_SQ:  f = sq;
      default:  f = lin;
    endcase
  end

endmodule

// File: rtl/sar_search_engine.sv
// MSB-first successive-approximation search for the largest x with f(x) <= target.
module sar_search_engine
  import sar_pkg::*;
#(
  parameter int XW       = 8,
  parameter int YW       = 10,
  parameter int GAIN     = 3,
  parameter int SQ_SHIFT = 6
) (
  input  logic                clk,
  input  logic                reset,
  sar_search_engine_if.slave  bus
);

  localparam int LW = XW + $clog2(GAIN + 1);
  localparam int SW = 2 * XW;
  localparam int FW = (LW > SW) ? LW : SW;
  localparam int CW = (FW > YW) ? FW : YW;
  localparam int IW = (XW > 1) ? $clog2(XW) : 1;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [IW-1:0] idx_q, idx_d, idx_m1;
  logic [YW-1:0] tgt_q, tgt_d;
  logic [YW-1:0] y_q, y_d;
  logic          mode_q, mode_d;
  logic          exact_q, exact_d;
  logic [FW-1:0] f_cur, f_nxt;
  logic [CW-1:0] tgt_w;

  // f_cur drives the trial decision; f_nxt tracks the code being registered so y stays aligned with x
  sar_func #(.XW(XW), .GAIN(GAIN), .SQ_SHIFT(SQ_SHIFT), .FW(FW)) u_cur (
    .x(x_q), .mode(mode_q), .f(f_cur)
  );
  sar_func #(.XW(XW), .GAIN(GAIN), .SQ_SHIFT(SQ_SHIFT), .FW(FW)) u_nxt (
    .x(x_d), .mode(mode_d), .f(f_nxt)
  );

  assign tgt_w  = CW'(tgt_q);
  assign idx_m1 = idx_q - 1'b1;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    exact_d = exact_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = TRIAL;
          tgt_d   = bus.target;
          mode_d  = bus.mode;
          x_d     = XW'(1) << (XW - 1);
          idx_d   = IW'(XW - 1);
          exact_d = 1'b0;
        end
      end
      TRIAL: begin
        if (CW'(f_cur) > tgt_w) x_d[idx_q] = 1'b0;
        if (idx_q != '0) begin
          x_d[idx_m1] = 1'b1;
          idx_d       = idx_m1;
        end else begin
          state_d = DONE;
          exact_d = (CW'(f_nxt) == tgt_w);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (CW'(f_nxt) > CW'({YW{1'b1}})) y_d = '1;
    else                              y_d = YW'(f_nxt);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      idx_q   <= '0;
      tgt_q   <= '0;
      mode_q  <= 1'b0;
      exact_q <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      exact_q <= exact_d;
      y_q     <= y_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.exact = exact_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_sar_search_engine.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor checks each done pulse.
module tb_sar_search_engine;
  import sar_pkg::*;

  localparam int XW = 8;
  localparam int YW = 10;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          exact;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;
  int   done_cnt = 0;
  int   cyc      = 0;
  int   acc      = 0;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sar_search_engine_if #(.XW(XW), .YW(YW)) bus ();

  sar_search_engine #(.XW(XW), .YW(YW), .GAIN(3), .SQ_SHIFT(6)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  task automatic check(input string name, input int act, input int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset && bus.done === 1'b1) begin
      done_cnt++;
      if (q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = q.pop_front();
        check("res_x", int'(bus.x), int'(e.x));
        check("res_y", int'(bus.y), int'(e.y));
        check("res_exact", int'(bus.exact), int'(e.exact));
      end
    end
  end

  task automatic push_exp(input int ex, input int ey, input bit ee);
    exp_t e;
    e.x = XW'(ex);
    e.y = YW'(ey);
    e.exact = ee;
    q.push_back(e);
  endtask

  // Leaves the caller at the negedge after the sampling edge, start already dropped
  task automatic launch(input logic m, input int t, input bit push,
                        input int ex, input int ey, input bit ee);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.target = YW'(t);
    if (push) push_exp(ex, ey, ee);
    acc = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) check({nm, "_timeout"}, 0, 1);
    else         check({nm, "_latency"}, cyc - acc, XW);
    @(negedge clk);
    check({nm, "_done_width"}, int'(bus.done), 0);
    check({nm, "_busy_idle"}, int'(bus.busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int d0, lows, dones;
    bus.start  = 1'b0;
    bus.mode   = MODE_LIN;
    bus.target = '0;
    #1;
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_exact", int'(bus.exact), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    launch(MODE_LIN, 550, 1, 183, 549, 0);
    wait_done("lin550");
    check("x_hold", int'(bus.x), 183);
    check("y_hold", int'(bus.y), 549);

    launch(MODE_LIN, 800, 1, 255, 765, 0);
    wait_done("lin800");
    launch(MODE_LIN, 300, 1, 100, 300, 1);
    wait_done("lin300");
    check("exact_hold", int'(bus.exact), 1);
    launch(MODE_SQ, 550, 1, 187, 546, 0);
    wait_done("sq550");
    launch(MODE_SQ, 1023, 1, 255, 1016, 0);
    wait_done("sq1023");
    launch(MODE_LIN, 0, 1, 0, 0, 1);
    wait_done("lin0");

    // spurious start mid-search with different target and mode
    d0 = done_cnt;
    launch(MODE_LIN, 550, 1, 183, 549, 0);
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.target = YW'(10); bus.mode = MODE_SQ;
    @(negedge clk);
    bus.start = 1'b0; bus.mode = MODE_LIN;
    wait_done("ignore");
    repeat (15) @(negedge clk);
    check("ignore_single_done", done_cnt - d0, 1);

    // reset asserted before the third trial edge
    d0 = done_cnt;
    launch(MODE_LIN, 550, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_x", int'(bus.x), 0);
    check("midrst_y", int'(bus.y), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    launch(MODE_LIN, 300, 1, 100, 300, 1);
    wait_done("postrst");

    // start held high for 30 cycles
    d0 = done_cnt;
    push_exp(183, 549, 0);
    push_exp(183, 549, 0);
    push_exp(183, 549, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = MODE_LIN; bus.target = YW'(550);
    lows = 0; dones = 0;
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) lows++;
      if (bus.done === 1'b1) dones++;
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy_low_cycles", lows, 2);
    check("b2b_done_cycles", dones, 3);
    repeat (15) @(negedge clk);
    check("b2b_done_count", done_cnt - d0, 3);
    check("sb_empty", q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
